// File: rtl/write_buffer.sv
// Posted-write FIFO between the cache controller and data memory.
// Optional macro WB_COALESCE_EN: merge a store into the youngest entry.
module write_buffer #(
  parameter int WIDTH   = 32,
  parameter int ADDRESS = 10,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_write,
  input  logic [ADDRESS-1:0] cpu_addr,
  input  logic [WIDTH-1:0]   cpu_data,
  output logic               wb_stall,
  input  logic [ADDRESS-1:0] lookup_addr,
  output logic               lookup_hit,
  output logic [WIDTH-1:0]   lookup_data,
  output logic               wb_empty,
  output logic               mem_write,
  output logic [ADDRESS-1:0] mem_addr,
  output logic [WIDTH-1:0]   mem_data,
  input  logic               mem_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } state_t;

  logic [ADDRESS-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0]   data_q [DEPTH];

  state_t             state_q, state_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW:0]        count_q, count_d;
  logic [ADDRESS-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]   mem_data_q, mem_data_d;

  logic               full;
  logic               push;
  logic               pop;
  logic               coal;
  logic [PW-1:0]      yng;
  logic [WIDTH-1:0]   head_data;
  logic [PW-1:0]      idx;

  assign full = (count_q == FULL);
  assign yng  = wr_ptr_q - PW'(1);

`ifdef WB_COALESCE_EN
  // Merge into the youngest entry unless it is the head already on the bus.
  assign coal = cpu_write && (count_q != '0)
             && (addr_q[yng] == cpu_addr)
             && !((state_q == WRITE) && (count_q == (PW+1)'(1)));
  assign head_data = (coal && (yng == rd_ptr_q)) ? cpu_data
                                                 : data_q[rd_ptr_q];
`else
  assign coal      = 1'b0;
  assign head_data = data_q[rd_ptr_q];
`endif

  assign push      = cpu_write & ~full & ~coal;
  assign pop       = (state_q == WRITE) & mem_ready;
  assign wb_stall  = cpu_write & full & ~coal;
  assign wb_empty  = (count_q == '0) & (state_q == IDLE);
  assign mem_write = (state_q == WRITE);
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;

  // Entry storage; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= cpu_addr;
      data_q[wr_ptr_q] <= cpu_data;
    end
    if (coal) begin
      data_q[yng] <= cpu_data;
    end
  end

  // Drain FSM next state, pointer/count update and bus register load.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
    mem_addr_d = '0;
    mem_data_d = '0;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = WRITE;
      WRITE:   if (mem_ready) state_d = GAP;
      GAP:     state_d = (count_q != '0) ? WRITE : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == WRITE) begin
      if (state_q == WRITE) begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
      end else begin
        mem_addr_d = addr_q[rd_ptr_q];
        mem_data_d = head_data;
      end
    end
  end

  // State registers with asynchronous reset that drops any write in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Forwarding search, oldest to youngest so the youngest match wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (addr_q[idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[idx];
      end
    end
  end

endmodule

// File: doc/write_buffer.md
# write_buffer

Posted-write FIFO between the cache controller and the data memory. It absorbs CPU stores under the write-through policy so the controller stalls only when the buffer is full, not for every main-memory write. It drains entries in order to the data memory with a write/ready handshake, and it offers a read-forwarding lookup and a drain-complete flag. The cache controller uses these to keep read misses coherent with pending writes.

## Interface
Parameters:
- WIDTH, 32, data word width
- ADDRESS, 10, word address width
- DEPTH, 4, number of entries (power of two, at least 2)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- cpu_write  input  1  store request from the cache controller
- cpu_addr  input  ADDRESS  store address
- cpu_data  input  WIDTH  store data
- wb_stall  output  1  store not accepted this cycle
- lookup_addr  input  ADDRESS  read-miss address to check against pending entries
- lookup_hit  output  1  some valid entry matches lookup_addr
- lookup_data  output  WIDTH  data of the youngest matching entry; 0 when no hit
- wb_empty  output  1  no valid entries and no write in flight
- mem_write  output  1  write request to the data memory
- mem_addr  output  ADDRESS  address of the head entry
- mem_data  output  WIDTH  data of the head entry
- mem_ready  input  1  data memory has completed the current write

## Operation
- Storage: circular FIFO of DEPTH entries holding {addr, data}.
  - Pointers wr_ptr and rd_ptr are each log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
  - full means count==DEPTH; empty means count==0.
- Push occurs when cpu_write=1 and count<DEPTH at the clock edge.
- wb_stall = cpu_write & (count==DEPTH). It is combinational and depends only on registered count.
- A pop in the same cycle does not unblock a full buffer; the store is retried the next cycle.
- Drain FSM states:
  - IDLE: mem_write=0. If count!=0, go to WRITE.
  - WRITE: mem_write=1, with mem_addr/mem_data taken from the head entry and held stable. If mem_ready=1, pop the head (rd_ptr+1, count-1) and go to GAP.
  - GAP: mem_write=0 for exactly one cycle, so the memory sees a deasserted request between writes. Then go to WRITE if count!=0, otherwise IDLE.
- Simultaneous push and pop (WRITE with mem_ready, count<DEPTH, cpu_write): count is unchanged, both pointers advance, and the new entry is placed correctly.
- Push into an empty buffer while in IDLE: the entry is visible to the drain FSM on the next edge.
- Lookup (combinational) searches all valid entries, including the head in flight.
  - The youngest match wins: the entry at the highest age from rd_ptr.
  - A store pushed at the current edge is not visible until after that edge.
- wb_empty = (count==0) & (state==IDLE). The controller must wait for wb_empty before a refill if it does not use lookup.
- Reset (asynchronous, any state, including mid-write):
  - count=0, pointers=0, state=IDLE, so mem_write drops immediately.
  - Pending entries are discarded.
  - Stored entry contents are don't-care.

## Timing
- Reset values:
  - wb_stall=0, lookup_hit=0, lookup_data=0, wb_empty=1
  - mem_write=0, mem_addr=0, mem_data=0
- Push to mem_write latency: push at edge k into an empty IDLE buffer gives state WRITE and mem_write=1 after edge k+1.
- Throughput: one write per (memory latency + 1 GAP cycle).
- mem_ready is sampled only in WRITE; it is ignored in IDLE and GAP.
- mem_addr/mem_data are registered copies of the head entry. They are stable for the whole WRITE phase and 0 outside WRITE.

## Configuration
- WB_COALESCE_EN defined:
  - A store whose cpu_addr equals the youngest valid entry's address overwrites that entry's data instead of pushing.
  - This applies only if that entry is not the head currently in WRITE.
  - Coalescing is allowed when full; wb_stall stays 0 for such a store.
- WB_COALESCE_EN undefined: every accepted store pushes a new entry, and same-address stores drain in order.

## Test plan
- Single store: rst pulse, then store addr=0x010 data=0xDEADBEEF; mem_ready after 4 cycles -> mem_write rises one cycle after push, holds addr/data for 4 cycles, and wb_empty=1 two cycles after mem_ready.
- Fill/stall: 5 back-to-back stores with DEPTH=4 and mem_ready held 0 -> first 4 accepted; wb_stall=1 on the 5th, which is accepted one cycle after the first mem_ready pop plus retry.
- Order and gap: stores A=1/0x11, B=2/0x22, C=3/0x33 with mem_ready=1 every WRITE cycle -> memory sees writes 1, 2, 3 in order, separated by one-cycle mem_write=0 gaps.
- Forwarding: stores 0x040=0xAAAA then 0x040=0xBBBB; lookup_addr=0x040 -> lookup_hit=1 and lookup_data=0xBBBB; lookup_addr=0x041 -> hit=0, data=0.
- Reset mid-write: assert rst during WRITE with 3 entries -> mem_write=0 immediately, wb_empty=1, and no further memory writes after release.
- Coalesce (WB_COALESCE_EN): head in flight at 0x100, then stores 0x200=5 and 0x200=6 -> one memory write to 0x200 with data 6. Without the macro -> two writes, 5 then 6.
